// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Request/response handshake and data-memory bus of the MEM
//               stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [31:0] dm_rdata;

  // Load/store unit side
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_err, resp_data,
    output dm_addr, dm_wdata, dm_MemRead, dm_MemWrite
  );

  // Pipeline (requester) side
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_data
  );

  // Data memory side
  modport memory (
    input  dm_addr, dm_wdata, dm_MemRead, dm_MemWrite,
    output dm_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store front end for a 256-byte big-endian data memory.
//               Issues word-aligned accesses, turns sub-word stores into a
//               read-modify-write and extends sub-word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned DM_BYTES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [31:0] c_dm_limit = DM_BYTES;

  logic [2:0]  r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_offset;
  logic        r_signed;
  logic [15:0] r_sdata;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merge;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // Request legality: size encoding, natural alignment and memory range
  always_comb begin
    w_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = bus.req_addr[0];
      2'b10:   w_err = (bus.req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (bus.req_addr >= c_dm_limit) begin
      w_err = 1'b1;
    end
  end

  // Big-endian lane extraction and sign/zero extension of the read word
  always_comb begin
    w_byte     = 8'h00;
    w_half     = r_offset[1] ? bus.dm_rdata[15:0] : bus.dm_rdata[31:16];
    w_load_val = bus.dm_rdata;
    case (r_offset)
      2'd0:    w_byte = bus.dm_rdata[31:24];
      2'd1:    w_byte = bus.dm_rdata[23:16];
      2'd2:    w_byte = bus.dm_rdata[15:8];
      default: w_byte = bus.dm_rdata[7:0];
    endcase
    case (r_size)
      2'b00:   w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_val = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_val = bus.dm_rdata;
    endcase
  end

  // Replace the target lane of the read word with the store data
  always_comb begin
    w_merge = bus.dm_rdata;
    if (r_size == 2'b00) begin
      case (r_offset)
        2'd0:    w_merge[31:24] = r_sdata[7:0];
        2'd1:    w_merge[23:16] = r_sdata[7:0];
        2'd2:    w_merge[15:8]  = r_sdata[7:0];
        default: w_merge[7:0]   = r_sdata[7:0];
      endcase
    end else if (r_offset[1]) begin
      w_merge[15:0] = r_sdata;
    end else begin
      w_merge[31:16] = r_sdata;
    end
  end

  // Access sequencer: captures the request, then walks the memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= 2'b00;
      r_offset    <= 2'b00;
      r_signed    <= 1'b0;
      r_sdata     <= 16'h0000;
      r_dm_addr   <= 32'h0;
      r_dm_wdata  <= 32'h0;
      r_resp_data <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_resp_data <= 32'h0;
            r_resp_err  <= w_err;
            r_size      <= bus.req_size;
            r_offset    <= bus.req_addr[1:0];
            r_signed    <= bus.req_signed;
            r_sdata     <= bus.req_wdata[15:0];
            r_dm_addr   <= {bus.req_addr[31:2], 2'b00};
            if (w_err) begin
              r_state <= S_DONE;
            end else if (!bus.req_write) begin
              r_state <= S_LOAD;
            end else if (bus.req_size == 2'b10) begin
              r_dm_wdata <= bus.req_wdata;
              r_state    <= S_WRITE;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          r_resp_data <= w_load_val;
          r_state     <= S_DONE;
        end
        S_RMW_RD: begin
          r_dm_wdata <= w_merge;
          r_state    <= S_RMW_WR;
        end
        S_WRITE, S_RMW_WR: r_state <= S_DONE;
        S_DONE:            r_state <= S_IDLE;
        default:           r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and handshakes decode from the registered state only
  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.resp_valid  = (r_state == S_DONE);
  assign bus.resp_err    = r_resp_err;
  assign bus.resp_data   = r_resp_data;
  assign bus.dm_addr     = r_dm_addr;
  assign bus.dm_wdata    = r_dm_wdata;
  assign bus.dm_MemRead  = (r_state == S_LOAD) || (r_state == S_RMW_RD);
  assign bus.dm_MemWrite = (r_state == S_WRITE) || (r_state == S_RMW_WR);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               byte-addressed big-endian memory model and response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   resp_count = 0;
  exp_t exp_q[$];
  logic [7:0] mem [0:255];

  mem_access_if bus ();

  mem_access_unit #(.DM_BYTES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory: combinational big-endian read, write at the clock edge
  always_comb begin
    bus.dm_rdata = {mem[bus.dm_addr[7:0]], mem[bus.dm_addr[7:0] + 8'd1],
                    mem[bus.dm_addr[7:0] + 8'd2], mem[bus.dm_addr[7:0] + 8'd3]};
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.dm_MemWrite) begin
      mem[bus.dm_addr[7:0]]         <= bus.dm_wdata[31:24];
      mem[bus.dm_addr[7:0] + 8'd1]  <= bus.dm_wdata[23:16];
      mem[bus.dm_addr[7:0] + 8'd2]  <= bus.dm_wdata[15:8];
      mem[bus.dm_addr[7:0] + 8'd3]  <= bus.dm_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) chk("strobe_exclusive", {31'd0, bus.dm_MemRead & bus.dm_MemWrite}, 32'd0);
    if (bus.resp_valid) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        chk("resp_data", bus.resp_data, e.data);
      end
    end
  end

  // One request: latency, strobe counts and write-strobe address/data
  task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_d, input int exp_lat,
                      input int exp_rd, input int exp_wr,
                      input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
    int lat = 0;
    int rdc = 0;
    int wrc = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    exp_q.push_back('{err: exp_err, data: exp_d});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.dm_MemRead) rdc++;
      if (bus.dm_MemWrite) begin
        wrc++;
        chk("dm_addr_on_write", bus.dm_addr, exp_waddr);
        chk("dm_wdata_on_write", bus.dm_wdata, exp_wdata);
      end
      if (bus.resp_valid) lat = n;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("memread_cycles", 32'(rdc), 32'(exp_rd));
    chk("memwrite_cycles", 32'(wrc), 32'(exp_wr));
  endtask

  initial begin
    int pulses;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset state
    #2;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, bus.dm_MemRead, bus.dm_MemWrite}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_dm_addr", bus.dm_addr, 32'h0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // Word store then loads of every lane flavour
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'h10, 32'hDEADBEEF);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAD, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h000000AD, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000DEAD, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000000EF, 2, 1, 0, 32'h0, 32'h0);

    // Byte store through read-modify-write
    xact(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF55, 1'b0, 32'h0, 3, 1, 1, 32'h10, 32'hDEAD55EF);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 2, 1, 0, 32'h0, 32'h0);

    // Illegal requests: no strobes, immediate error response
    xact(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    xact(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    xact(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);

    // Half store aborted by reset while reading
    @(negedge clk);
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h00001234;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("abort_in_rmw_rd", {31'd0, bus.dm_MemRead}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_outputs", {29'd0, bus.resp_valid, bus.dm_MemRead, bus.dm_MemWrite}, 32'd0);
    chk("abort_resp_data", bus.resp_data, 32'h0);
    chk("abort_dm_addr", bus.dm_addr, 32'h0);
    chk("abort_dm_wdata", bus.dm_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = resp_count;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 32'(resp_count - pulses), 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 2, 1, 0, 32'h0, 32'h0);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_valid  = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 32'hDEAD55EF});
    pulses = resp_count;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2 || c == 4 || c == 5) chk("b2b_ready_low", {31'd0, bus.req_ready}, 32'd0);
      if (c == 3) chk("b2b_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      if (c == 2) begin
        chk("b2b_first_resp", {31'd0, bus.resp_valid}, 32'd1);
        bus.req_size = 2'b00;
        bus.req_addr = 32'h13;
        exp_q.push_back('{err: 1'b0, data: 32'h000000EF});
      end
      if (c == 4) bus.req_valid = 1'b0;
      if (c == 5) chk("b2b_second_resp", {31'd0, bus.resp_valid}, 32'd1);
    end
    chk("b2b_pulse_count", 32'(resp_count - pulses), 32'd2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
